// File: rtl/uart_dbus_bridge_core.sv
// Byte bridge between a UART and a DBUS-style port: two four-phase source engines,
// two elastic FIFOs and two holdoff-paced strobe sinks, with a loopback/halt mode switch.
module uart_dbus_bridge_core #(
    parameter int c_DATAWIDTH  = 8,
    parameter int c_DEPTHPOW2  = 2,
    parameter int c_SYNCSTAGES = 2,
    parameter int c_CNTWIDTH   = 16
) (
    input  logic                   i_clock,
    input  logic                   i_resetn,
    input  logic [1:0]             i_mode,
    input  logic                   i_a_avail,
    input  logic [c_DATAWIDTH-1:0] i_a_data,
    output logic                   o_a_read,
    input  logic                   i_b_busy,
    output logic                   o_b_enable,
    output logic [c_DATAWIDTH-1:0] o_b_data,
    input  logic                   i_c_avail,
    input  logic [c_DATAWIDTH-1:0] i_c_data,
    output logic                   o_c_read,
    input  logic                   i_d_busy,
    output logic                   o_d_enable,
    output logic [c_DATAWIDTH-1:0] o_d_data,
    output logic [1:0]             o_mode_active,
    output logic [c_DEPTHPOW2:0]   o_ab_level,
    output logic [c_DEPTHPOW2:0]   o_cd_level,
    output logic [c_CNTWIDTH-1:0]  o_ab_count,
    output logic [c_CNTWIDTH-1:0]  o_cd_count,
    output logic [c_CNTWIDTH-1:0]  o_drop_count
);
    localparam int              PW        = c_DEPTHPOW2 + 1;
    localparam int              DEPTH     = 1 << c_DEPTHPOW2;
    localparam logic [2:0]      HOLD_LOAD = 3'(c_SYNCSTAGES + 1);
    localparam logic [PW-1:0]   FULL_XOR  = PW'(1) << c_DEPTHPOW2;

    typedef enum logic {SRC_IDLE = 1'b0, SRC_WAIT = 1'b1} src_state_e;

    // Status synchroniser, one 4-bit slice per stage: {d_busy, c_avail, b_busy, a_avail}.
    logic [3:0] sync_q [c_SYNCSTAGES];
    logic a_av_s, b_busy_s, c_av_s, d_busy_s;

    src_state_e a_st_q, a_st_d, c_st_q, c_st_d;
    logic [PW-1:0] ab_wr_q, ab_rd_q, cd_wr_q, cd_rd_q;
    logic [c_DATAWIDTH-1:0] ab_mem_q [DEPTH];
    logic [c_DATAWIDTH-1:0] cd_mem_q [DEPTH];
    logic [c_DATAWIDTH-1:0] cd_wdata;
    logic [2:0] b_hold_q, d_hold_q;
    logic [1:0] mode_q;
    logic [c_CNTWIDTH-1:0] ab_cnt_q, cd_cnt_q, drop_cnt_q;
    logic b_en_q, d_en_q;
    logic [c_DATAWIDTH-1:0] b_data_q, d_data_q;

    logic ab_empty, ab_full, cd_empty, cd_full;
    logic bridge, loop, quiet, mode_load;
    logic ab_push, cd_push_a, cd_push_c, cd_push, drop_inc;
    logic b_fire, d_fire;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < c_SYNCSTAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {i_d_busy, i_c_avail, i_b_busy, i_a_avail};
            for (int i = 1; i < c_SYNCSTAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign a_av_s   = sync_q[c_SYNCSTAGES-1][0];
    assign b_busy_s = sync_q[c_SYNCSTAGES-1][1];
    assign c_av_s   = sync_q[c_SYNCSTAGES-1][2];
    assign d_busy_s = sync_q[c_SYNCSTAGES-1][3];

    assign ab_empty   = (ab_wr_q == ab_rd_q);
    assign cd_empty   = (cd_wr_q == cd_rd_q);
    assign ab_full    = ((ab_wr_q ^ ab_rd_q) == FULL_XOR);
    assign cd_full    = ((cd_wr_q ^ cd_rd_q) == FULL_XOR);
    assign o_ab_level = ab_wr_q - ab_rd_q;
    assign o_cd_level = cd_wr_q - cd_rd_q;

    assign bridge    = (mode_q == 2'b00);
    assign loop      = (mode_q == 2'b01);
    assign quiet     = ab_empty && cd_empty && (a_st_q == SRC_IDLE) && (c_st_q == SRC_IDLE);
    // New handshakes are held off on the switching cycle so no byte lands under the old routing.
    assign mode_load = quiet && (i_mode != mode_q);

    // Four-phase source handshake: read rises on the edge the byte is pushed and
    // stays high until the synchronised avail has dropped.
    always_comb begin
        a_st_d    = a_st_q;
        c_st_d    = c_st_q;
        ab_push   = 1'b0;
        cd_push_a = 1'b0;
        cd_push_c = 1'b0;
        drop_inc  = 1'b0;
        case (a_st_q)
            SRC_IDLE: begin
                if (!mode_load && a_av_s && ((bridge && !ab_full) || (loop && !cd_full))) begin
                    a_st_d    = SRC_WAIT;
                    ab_push   = bridge;
                    cd_push_a = loop;
                end
            end
            default: if (!a_av_s) a_st_d = SRC_IDLE;
        endcase
        case (c_st_q)
            SRC_IDLE: begin
                if (!mode_load && c_av_s && ((bridge && !cd_full) || loop)) begin
                    c_st_d    = SRC_WAIT;
                    cd_push_c = bridge;
                    drop_inc  = loop;
                end
            end
            default: if (!c_av_s) c_st_d = SRC_IDLE;
        endcase
    end

    assign cd_push  = cd_push_a || cd_push_c;
    assign cd_wdata = cd_push_c ? i_c_data : i_a_data;
    assign b_fire   = bridge && !ab_empty && !b_busy_s && (b_hold_q == 3'd0);
    assign d_fire   = (bridge || loop) && !cd_empty && !d_busy_s && (d_hold_q == 3'd0);

    always_ff @(posedge i_clock) begin
        if (ab_push) ab_mem_q[ab_wr_q[PW-2:0]] <= i_a_data;
        if (cd_push) cd_mem_q[cd_wr_q[PW-2:0]] <= cd_wdata;
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            a_st_q     <= SRC_IDLE;
            c_st_q     <= SRC_IDLE;
            ab_wr_q    <= '0;
            ab_rd_q    <= '0;
            cd_wr_q    <= '0;
            cd_rd_q    <= '0;
            b_hold_q   <= '0;
            d_hold_q   <= '0;
            b_en_q     <= 1'b0;
            d_en_q     <= 1'b0;
            b_data_q   <= '0;
            d_data_q   <= '0;
            mode_q     <= 2'b10;
            ab_cnt_q   <= '0;
            cd_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            a_st_q <= a_st_d;
            c_st_q <= c_st_d;
            if (ab_push) ab_wr_q <= ab_wr_q + PW'(1);
            if (cd_push) cd_wr_q <= cd_wr_q + PW'(1);
            if (b_fire)  ab_rd_q <= ab_rd_q + PW'(1);
            if (d_fire)  cd_rd_q <= cd_rd_q + PW'(1);
            if (mode_load) mode_q <= i_mode;
            b_en_q <= b_fire;
            d_en_q <= d_fire;
            if (b_fire) b_data_q <= ab_mem_q[ab_rd_q[PW-2:0]];
            if (d_fire) d_data_q <= cd_mem_q[cd_rd_q[PW-2:0]];
            // Holdoff covers the busy synchroniser latency so a stale busy=0 is never trusted.
            if (b_fire)                 b_hold_q <= HOLD_LOAD;
            else if (b_hold_q != 3'd0)  b_hold_q <= b_hold_q - 3'd1;
            if (d_fire)                 d_hold_q <= HOLD_LOAD;
            else if (d_hold_q != 3'd0)  d_hold_q <= d_hold_q - 3'd1;
            if (b_fire && ab_cnt_q != '1)     ab_cnt_q   <= ab_cnt_q + 1'b1;
            if (d_fire && cd_cnt_q != '1)     cd_cnt_q   <= cd_cnt_q + 1'b1;
            if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign o_a_read      = (a_st_q == SRC_WAIT);
    assign o_c_read      = (c_st_q == SRC_WAIT);
    assign o_b_enable    = b_en_q;
    assign o_d_enable    = d_en_q;
    assign o_b_data      = b_data_q;
    assign o_d_data      = d_data_q;
    assign o_mode_active = mode_q;
    assign o_ab_count    = ab_cnt_q;
    assign o_cd_count    = cd_cnt_q;
    assign o_drop_count  = drop_cnt_q;

endmodule
